// File: rtl/stream_out_downsize.sv
// Width-down converter: each 1536-bit result word leaves as three 512-bit AXI-Stream beats.
// Any set s_tlast bit turns into m_tlast on the word's final beat; word/packet counters are for debug.
module stream_out_downsize #(
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1535:0]    s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [23:0]      s_tlast,
    output logic [511:0]     m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [63:0]      m_tkeep,
    output logic             m_tlast,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] pkt_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1535:0]    r_buf;
    logic             r_buf_last;
    logic             r_full;
    logic [1:0]       r_beat;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_pkt_cnt;

    logic             w_last_beat;
    logic             w_s_hs;
    logic             w_m_hs;
    logic [511:0]     w_slice;

    // Valid/ready on both sides: a transfer occurs on a rising edge where valid and ready are both 1;
    // m_tvalid comes from registered state only, s_tready may look at m_tready so a new word
    // can load in the same cycle the final beat leaves.
    assign w_last_beat = r_full && (r_beat == 2'd2);
    assign s_tready    = !r_full || (w_last_beat && m_tready);
    assign w_s_hs      = s_tvalid && s_tready;
    assign w_m_hs      = r_full && m_tready;

    always_comb begin
        w_slice = '0;
        case (r_beat)
            2'd0:    w_slice = (LSB_FIRST != 0) ? r_buf[511:0] : r_buf[1535:1024];
            2'd1:    w_slice = r_buf[1023:512];
            2'd2:    w_slice = (LSB_FIRST != 0) ? r_buf[1535:1024] : r_buf[511:0];
            default: w_slice = '0;
        endcase
    end

    assign m_tvalid = r_full;
    assign m_tdata  = r_full ? w_slice : '0;
    assign m_tkeep  = {64{r_full}};
    assign m_tlast  = w_last_beat && r_buf_last;
    assign word_cnt = r_word_cnt;
    assign pkt_cnt  = r_pkt_cnt;

    // An accept always wins over the final-beat drain, so full stays set across back-to-back words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '0;
            r_buf_last <= 1'b0;
            r_full     <= 1'b0;
            r_beat     <= 2'd0;
            r_word_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_s_hs) begin
                r_buf      <= s_tdata;
                r_buf_last <= |s_tlast;
                r_full     <= 1'b1;
                r_beat     <= 2'd0;
            end else if (w_m_hs) begin
                if (r_beat == 2'd2) begin
                    r_full <= 1'b0;
                    r_beat <= 2'd0;
                end else begin
                    r_beat <= r_beat + 2'd1;
                end
            end
            if (w_s_hs) begin
                r_word_cnt <= r_word_cnt + CNT_ONE;
            end
            if (w_m_hs && m_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_stream_out_downsize.sv
// Bench for stream_out_downsize: two instances (LSB-first/16-bit counters and MSB-first/4-bit counters)
// share one stimulus stream and are compared against a queue-based beat model every cycle.
module tb_stream_out_downsize;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1535:0] s_tdata;
    logic          s_tvalid;
    logic [23:0]   s_tlast;
    logic          m_tready;

    logic          a_s_tready, b_s_tready;
    logic [511:0]  a_m_tdata, b_m_tdata;
    logic          a_m_tvalid, b_m_tvalid;
    logic [63:0]   a_m_tkeep, b_m_tkeep;
    logic          a_m_tlast, b_m_tlast;
    logic [15:0]   a_word_cnt, a_pkt_cnt;
    logic [3:0]    b_word_cnt, b_pkt_cnt;

    stream_out_downsize #(.LSB_FIRST(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(a_s_tready),
        .s_tlast(s_tlast), .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(m_tready),
        .m_tkeep(a_m_tkeep), .m_tlast(a_m_tlast), .word_cnt(a_word_cnt), .pkt_cnt(a_pkt_cnt)
    );

    stream_out_downsize #(.LSB_FIRST(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(b_s_tready),
        .s_tlast(s_tlast), .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(m_tready),
        .m_tkeep(b_m_tkeep), .m_tlast(b_m_tlast), .word_cnt(b_word_cnt), .pkt_cnt(b_pkt_cnt)
    );

    typedef struct {
        logic [23:0] tlast;
        logic [7:0]  seed;
        logic        exp_last;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [512:0] exp_q_a[$];
    logic [512:0] exp_q_b[$];
    int words = 0;
    int pkts = 0;
    logic acc = 1'b0;
    int beat_cnt, first_cyc, last_cyc, tlast_n, tlast_beat;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0b expected=%0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1535:0] make_word(input logic [7:0] seed);
        logic [7:0] b0, b1, b2;
        b0 = seed;
        b1 = seed + 8'd1;
        b2 = seed + 8'd2;
        return {{64{b2}}, {64{b1}}, {64{b0}}};
    endfunction

    function automatic logic [1535:0] rand_word();
        logic [1535:0] w;
        for (int i = 0; i < 48; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Model: a word is three queued beats; one beat drains per ready cycle, and a new word
    // is taken only when nothing, or just the last beat being drained, remains.
    task automatic half_check();
        int n;
        logic e_valid, e_sready;
        logic [512:0] fa, fb;
        @(negedge clk);
        cyc++;
        n = exp_q_a.size();
        e_valid = (n != 0);
        e_sready = (n == 0) || (n == 1 && m_tready);
        chk_bit("a_m_tvalid", a_m_tvalid, e_valid);
        chk_bit("b_m_tvalid", b_m_tvalid, e_valid);
        chk_bit("a_s_tready", a_s_tready, e_sready);
        chk_bit("b_s_tready", b_s_tready, e_sready);
        chk64("a_m_tkeep", a_m_tkeep, {64{e_valid}});
        chk64("b_m_tkeep", b_m_tkeep, {64{e_valid}});
        if (e_valid) begin
            fa = exp_q_a[0];
            fb = exp_q_b[0];
            chk_wide("a_m_tdata", a_m_tdata, fa[511:0]);
            chk_wide("b_m_tdata", b_m_tdata, fb[511:0]);
            chk_bit("a_m_tlast", a_m_tlast, fa[512]);
            chk_bit("b_m_tlast", b_m_tlast, fb[512]);
        end else begin
            fa = '0;
            chk_bit("a_idle_tlast", a_m_tlast, 1'b0);
            chk_bit("b_idle_tlast", b_m_tlast, 1'b0);
        end
        chk_int("a_word_cnt", int'(a_word_cnt), words % 65536);
        chk_int("a_pkt_cnt", int'(a_pkt_cnt), pkts % 65536);
        chk_int("b_word_cnt", int'(b_word_cnt), words % 16);
        chk_int("b_pkt_cnt", int'(b_pkt_cnt), pkts % 16);
        if (a_m_tvalid && m_tready) begin
            beat_cnt++;
            if (beat_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (a_m_tlast) begin
                tlast_n++;
                tlast_beat = beat_cnt;
            end
        end
        if (e_valid && m_tready) begin
            if (fa[512]) pkts++;
            void'(exp_q_a.pop_front());
            void'(exp_q_b.pop_front());
        end
        acc = s_tvalid && e_sready;
        if (acc) begin
            for (int k = 0; k < 3; k++) begin
                exp_q_a.push_back({(k == 2) && (s_tlast != 24'h0), s_tdata[k*512 +: 512]});
                exp_q_b.push_back({(k == 2) && (s_tlast != 24'h0), s_tdata[(2-k)*512 +: 512]});
            end
            words++;
        end
    endtask

    task automatic half_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half_check();
        half_edge();
    endtask

    // Called #1 after a rising edge; reset asserts mid-cycle and releases #1 after the next edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_bit({tag, "_a_tvalid"}, a_m_tvalid, 1'b0);
        chk_bit({tag, "_b_tvalid"}, b_m_tvalid, 1'b0);
        chk_bit({tag, "_a_s_tready"}, a_s_tready, 1'b1);
        chk_bit({tag, "_a_tlast"}, a_m_tlast, 1'b0);
        chk64({tag, "_a_tkeep"}, a_m_tkeep, 64'h0);
        chk_wide({tag, "_a_tdata"}, a_m_tdata, 512'h0);
        chk_wide({tag, "_b_tdata"}, b_m_tdata, 512'h0);
        chk_int({tag, "_a_word"}, int'(a_word_cnt), 0);
        chk_int({tag, "_a_pkt"}, int'(a_pkt_cnt), 0);
        chk_int({tag, "_b_word"}, int'(b_word_cnt), 0);
        exp_q_a.delete();
        exp_q_b.delete();
        words = 0;
        pkts = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic stream_words(input int n, input bit all_last, input string tag);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = rand_word();
        s_tlast = (all_last || n == 1) ? 24'h800000 : 24'h0;
        while ((idx < n || exp_q_a.size() != 0) && guard < 400) begin
            step();
            guard++;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    s_tdata = rand_word();
                    s_tlast = (all_last || idx == n - 1) ? 24'h000100 : 24'h0;
                end else begin
                    s_tvalid = 1'b0;
                end
            end
        end
        chk_bit({tag, "_no_timeout"}, guard < 400, 1'b1);
    endtask

    initial begin
        vec_t tbl[5];
        int pb, wb, idx, guard;
        logic [7:0] bb;

        tbl[0] = '{tlast: 24'h800000, seed: 8'hAA, exp_last: 1'b1};
        tbl[1] = '{tlast: 24'h000000, seed: 8'h10, exp_last: 1'b0};
        tbl[2] = '{tlast: 24'h000001, seed: 8'h20, exp_last: 1'b1};
        tbl[3] = '{tlast: 24'h010000, seed: 8'h30, exp_last: 1'b1};
        tbl[4] = '{tlast: 24'h000000, seed: 8'hF0, exp_last: 1'b0};

        s_tdata = '0;
        s_tvalid = 1'b0;
        s_tlast = '0;
        m_tready = 1'b0;
        do_reset("reset0");

        for (int i = 0; i < 5; i++) begin
            pb = pkts;
            s_tdata = make_word(tbl[i].seed);
            s_tlast = tbl[i].tlast;
            s_tvalid = 1'b1;
            m_tready = 1'b1;
            step();
            s_tvalid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                half_check();
                bb = tbl[i].seed + 8'(k);
                chk_wide("tbl_a_beat", a_m_tdata, {64{bb}});
                bb = tbl[i].seed + 8'(2 - k);
                chk_wide("tbl_b_beat", b_m_tdata, {64{bb}});
                chk_bit("tbl_a_last", a_m_tlast, (k == 2) && tbl[i].exp_last);
                half_edge();
            end
            half_check();
            chk_bit("tbl_idle", a_m_tvalid, 1'b0);
            half_edge();
            chk_int("tbl_pkt", int'(a_pkt_cnt), pb + (tbl[i].exp_last ? 1 : 0));
        end

        beat_cnt = 0; tlast_n = 0; tlast_beat = 0; first_cyc = 0; last_cyc = 0;
        wb = words;
        pb = pkts;
        stream_words(8, 1'b0, "stream8");
        step();
        chk_int("stream_beats", beat_cnt, 24);
        chk_int("stream_span", last_cyc - first_cyc, 23);
        chk_int("stream_tlast_n", tlast_n, 1);
        chk_int("stream_tlast_at", tlast_beat, 24);
        chk_int("stream_word_cnt", int'(a_word_cnt), wb + 8);
        chk_int("stream_pkt_cnt", int'(a_pkt_cnt), pb + 1);

        idx = 0;
        guard = 0;
        s_tvalid = 1'b0;
        while ((idx < 100 || exp_q_a.size() != 0) && guard < 3000) begin
            if (!s_tvalid && idx < 100 && $urandom_range(0, 3) != 0) begin
                s_tvalid = 1'b1;
                s_tdata = rand_word();
                s_tlast = 24'h0;
                if ($urandom_range(0, 3) == 0) s_tlast[$urandom_range(0, 23)] = 1'b1;
            end
            m_tready = 1'($urandom_range(0, 1));
            step();
            guard++;
            if (acc) begin
                idx++;
                s_tvalid = 1'b0;
            end
        end
        chk_bit("random_no_timeout", guard < 3000, 1'b1);
        chk_int("random_word_cnt", int'(a_word_cnt), words % 65536);

        s_tdata = rand_word();
        s_tlast = 24'h000001;
        s_tvalid = 1'b1;
        m_tready = 1'b0;
        step();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        step();
        step();
        do_reset("midreset");
        s_tdata = make_word(8'h50);
        s_tlast = 24'h400000;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        beat_cnt = 0; tlast_n = 0;
        step();
        s_tvalid = 1'b0;
        repeat (4) step();
        chk_int("post_reset_beats", beat_cnt, 3);
        chk_int("post_reset_tlast_n", tlast_n, 1);
        chk_int("post_reset_word", int'(a_word_cnt), 1);
        chk_int("post_reset_pkt", int'(a_pkt_cnt), 1);

        do_reset("wrapreset");
        stream_words(17, 1'b1, "wrap17");
        step();
        chk_int("wrap_b_word", int'(b_word_cnt), 1);
        chk_int("wrap_b_pkt", int'(b_pkt_cnt), 1);
        chk_int("wrap_a_word", int'(a_word_cnt), 17);
        chk_int("wrap_a_pkt", int'(a_pkt_cnt), 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
